// File: rtl/serial_port_ctrl_pkg.sv
// Shared UART address map and controller state encoding.
package serial_port_ctrl_pkg;

    localparam logic [15:0] UART_DATA_ADDR = 16'hBF00;
    localparam logic [15:0] UART_STAT_ADDR = 16'hBF01;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_LOW  = 3'd1,
        WR_LOW  = 3'd2,
        WR_TBRE = 3'd3,
        WR_TSRE = 3'd4,
        DONE    = 3'd5
    } uart_state_t;

endpackage

// File: rtl/serial_port_ctrl_sync2.sv
// Two-flop synchronizer for asynchronous UART status lines.
module sync2 (
    input  logic CLK,
    input  logic RST,
    input  logic d,
    output logic q
);

    logic meta;

    // Resample the asynchronous input twice before use
    always_ff @(posedge CLK) begin
        if (RST) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/serial_port_ctrl.sv
// MEM-stage slave for the memory-mapped UART: address decode, strobe
// sequencing on the shared low data byte, and pipeline stall generation.
module serial_port_ctrl
    import serial_port_ctrl_pkg::*;
#(
    parameter logic [15:0] DATA_ADDR = UART_DATA_ADDR,
    parameter logic [15:0] STAT_ADDR = UART_STAT_ADDR,
    parameter int unsigned RD_CYCLES = 2,
    parameter int unsigned WR_CYCLES = 2,
    parameter int unsigned TIMEOUT   = 4095
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        stall,
    output logic [15:0] rdata,
    output logic        rdata_valid,
    output logic        ram1_release,
    input  logic [7:0]  bus_din,
    output logic [7:0]  bus_dout,
    output logic        bus_oe,
    output logic        rdn,
    output logic        wrn,
    input  logic        data_ready,
    input  logic        tbre,
    input  logic        tsre
);

    localparam logic [3:0]  RD_LAST = 4'(RD_CYCLES - 1);
    localparam logic [3:0]  WR_HOLD = 4'(WR_CYCLES);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    uart_state_t state_q, state_d;
    logic [3:0]  cnt_q;
    logic [15:0] wcnt_q;
    logic        is_load_q;
    logic [7:0]  rdata_q;
    logic [7:0]  bus_dout_q;
    logic        data_ready_s, tbre_s, tsre_s;
    logic        hit_d, hit_s, tx_rdy_s;
    logic        unused_wdata_hi;

    assign unused_wdata_hi = ^req_wdata[15:8];

    sync2 u_sync_rx   (.CLK(CLK), .RST(RST), .d(data_ready), .q(data_ready_s));
    sync2 u_sync_tbre (.CLK(CLK), .RST(RST), .d(tbre),       .q(tbre_s));
    sync2 u_sync_tsre (.CLK(CLK), .RST(RST), .d(tsre),       .q(tsre_s));

    assign hit_d    = req_valid && (req_addr == DATA_ADDR);
    assign hit_s    = req_valid && (req_addr == STAT_ADDR);
    assign tx_rdy_s = tbre_s && tsre_s && (state_q == IDLE);

    // State register
    always_ff @(posedge CLK) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; one wait counter spans both TX-empty waits
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (hit_d) state_d = req_write ? WR_LOW : RD_LOW;
            RD_LOW:  if (cnt_q == RD_LAST) state_d = DONE;
            WR_LOW:  if (cnt_q == WR_HOLD) state_d = WR_TBRE;
            WR_TBRE: begin
                if (tbre_s)                 state_d = WR_TSRE;
                else if (wcnt_q >= TO_LAST) state_d = DONE;
            end
            WR_TSRE: if (tsre_s || (wcnt_q >= TO_LAST)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Phase counters, captured load byte and latched store byte
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q      <= '0;
            wcnt_q     <= '0;
            is_load_q  <= 1'b0;
            rdata_q    <= '0;
            bus_dout_q <= '0;
        end else begin
            if ((state_d == state_q) && ((state_q == RD_LOW) || (state_q == WR_LOW)))
                cnt_q <= cnt_q + 4'd1;
            else
                cnt_q <= '0;
            if ((state_q == WR_TBRE) || (state_q == WR_TSRE))
                wcnt_q <= wcnt_q + 16'd1;
            else
                wcnt_q <= '0;
            if ((state_q == IDLE) && hit_d) begin
                is_load_q <= ~req_write;
                if (req_write) bus_dout_q <= req_wdata[7:0];
            end
            if ((state_q == RD_LOW) && (cnt_q == RD_LAST))
                rdata_q <= bus_din;
        end
    end

    // Strobes, bus ownership, stall and read-data outputs
    always_comb begin
        rdn          = 1'b1;
        wrn          = 1'b1;
        bus_oe       = 1'b0;
        ram1_release = 1'b0;
        bus_dout     = bus_dout_q;
        stall        = hit_d && (state_q != DONE);
        rdata        = hit_s ? {14'b0, data_ready_s, tx_rdy_s} : {8'b0, rdata_q};
        rdata_valid  = (hit_s && !req_write) || ((state_q == DONE) && is_load_q);
        unique case (state_q)
            RD_LOW: begin
                rdn          = 1'b0;
                ram1_release = 1'b1;
            end
            WR_LOW: begin
                // cnt 0 is data setup, cnt WR_HOLD is the data hold cycle
                bus_oe       = 1'b1;
                ram1_release = 1'b1;
                wrn          = !((cnt_q != 4'd0) && (cnt_q < WR_HOLD));
            end
            WR_TBRE, WR_TSRE: ram1_release = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_serial_port_ctrl.sv
// Self-checking bench for serial_port_ctrl: cycle-indexed timelines derived
// from the access-timing rules, with randomized data, delays and addresses.
module tb_serial_port_ctrl;

    localparam int RD = 2;
    localparam int WR = 2;
    localparam int TO = 16;
    localparam logic [15:0] A_DATA = 16'hBF00;
    localparam logic [15:0] A_STAT = 16'hBF01;
    localparam logic [5:0]  F_IDLE = 6'b011000;  // {stall,rdn,wrn,oe,rel,valid}

    logic        CLK = 1'b0;
    logic        RST;
    logic        req_valid, req_valid_t, req_write;
    logic [15:0] req_addr, req_wdata;
    logic [7:0]  bus_din;
    logic        data_ready, tbre, tsre;

    logic        stall, rdata_valid, ram1_release, bus_oe, rdn, wrn;
    logic [15:0] rdata;
    logic [7:0]  bus_dout;
    logic        stall_t, rdata_valid_t, ram1_release_t, bus_oe_t, rdn_t, wrn_t;
    logic [15:0] rdata_t;
    logic [7:0]  bus_dout_t;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    serial_port_ctrl #(.RD_CYCLES(RD), .WR_CYCLES(WR), .TIMEOUT(4095)) dut (
        .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall), .rdata(rdata),
        .rdata_valid(rdata_valid), .ram1_release(ram1_release), .bus_din(bus_din),
        .bus_dout(bus_dout), .bus_oe(bus_oe), .rdn(rdn), .wrn(wrn),
        .data_ready(data_ready), .tbre(tbre), .tsre(tsre)
    );

    serial_port_ctrl #(.RD_CYCLES(RD), .WR_CYCLES(WR), .TIMEOUT(TO)) dut_t (
        .CLK(CLK), .RST(RST), .req_valid(req_valid_t), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall_t), .rdata(rdata_t),
        .rdata_valid(rdata_valid_t), .ram1_release(ram1_release_t), .bus_din(bus_din),
        .bus_dout(bus_dout_t), .bus_oe(bus_oe_t), .rdn(rdn_t), .wrn(wrn_t),
        .data_ready(data_ready), .tbre(tbre), .tsre(tsre)
    );

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        for (int k = 0; k < n; k++) next_cycle();
    endtask

    function automatic logic [5:0] flags_main();
        return {stall, rdn, wrn, bus_oe, ram1_release, rdata_valid};
    endfunction

    function automatic logic [5:0] flags_t();
        return {stall_t, rdn_t, wrn_t, bus_oe_t, ram1_release_t, rdata_valid_t};
    endfunction

    task automatic test_reset();
        RST = 1'b1; req_valid = 0; req_valid_t = 0; req_write = 0;
        req_addr = '0; req_wdata = '0; bus_din = '0;
        data_ready = 0; tbre = 0; tsre = 0;
        #1;
        wait_cycles(3);
        @(negedge CLK);
        n_cmp++;
        if (flags_main() !== F_IDLE || rdata !== 16'h0 || bus_dout !== 8'h0) begin
            n_err++;
            $display("FAIL reset flags=%b rdata=%h dout=%h want %b 0000 00", flags_main(), rdata, bus_dout, F_IDLE);
        end
        n_cmp++;
        if (flags_t() !== F_IDLE) begin
            n_err++;
            $display("FAIL reset_t flags=%b want %b", flags_t(), F_IDLE);
        end
        next_cycle();
        RST = 1'b0;
        next_cycle();
    endtask

    task automatic test_status_read();
        logic dr, tb, ts;
        logic [15:0] exp;
        for (int it = 0; it < 6; it++) begin
            dr = (it == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            tb = (it == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            ts = (it == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            data_ready = dr; tbre = tb; tsre = ts;
            wait_cycles(3);
            req_valid = 1; req_write = 0; req_addr = A_STAT;
            exp = {14'b0, dr, tb & ts};
            @(negedge CLK);
            n_cmp++;
            if (rdata !== exp || flags_main() !== 6'b011001) begin
                n_err++;
                $display("FAIL status_rd[%0d] rdata=%h flags=%b want %h 011001", it, rdata, flags_main(), exp);
            end
            next_cycle();
            req_write = 1; req_wdata = 16'($urandom);
            @(negedge CLK);
            n_cmp++;
            if (flags_main() !== F_IDLE) begin
                n_err++;
                $display("FAIL status_wr[%0d] flags=%b want %b", it, flags_main(), F_IDLE);
            end
            next_cycle();
            req_valid = 0; req_write = 0;
        end
    endtask

    // Loads; with b2b the next load is presented in the cycle right after DONE
    task automatic test_load(input int count, input bit b2b);
        logic [7:0] din;
        logic [5:0] exp_f;
        for (int j = 0; j < count; j++) begin
            din = 8'($urandom);
            bus_din = din; req_valid = 1; req_write = 0; req_addr = A_DATA;
            req_wdata = 16'($urandom);
            for (int i = 0; i <= RD + 1; i++) begin
                if (i == RD + 1) bus_din = ~din;
                @(negedge CLK);
                exp_f = {i <= RD, !(i >= 1 && i <= RD), 1'b1, 1'b0, (i >= 1 && i <= RD), i == RD + 1};
                n_cmp++;
                if (flags_main() !== exp_f) begin
                    n_err++;
                    $display("FAIL load[%0d] b2b=%0d cyc%0d flags=%b want %b", j, b2b, i, flags_main(), exp_f);
                end
                if (i == RD + 1) begin
                    n_cmp++;
                    if (rdata !== {8'h00, din}) begin
                        n_err++;
                        $display("FAIL load_data[%0d] rdata=%h want %h", j, rdata, {8'h00, din});
                    end
                end
                next_cycle();
            end
            if (!b2b) begin
                req_valid = 0;
                wait_cycles(1 + $urandom_range(0, 2));
            end
        end
        req_valid = 0;
    endtask

    task automatic test_other_addr();
        logic [15:0] a;
        for (int it = 0; it < 5; it++) begin
            a = (it == 0) ? 16'h8000 : 16'($urandom);
            if (a == A_DATA || a == A_STAT) a = 16'h8000;
            req_valid = 1; req_addr = a; req_write = 1'($urandom_range(0, 1));
            req_wdata = 16'($urandom);
            for (int i = 0; i < 3; i++) begin
                @(negedge CLK);
                n_cmp++;
                if (flags_main() !== F_IDLE) begin
                    n_err++;
                    $display("FAIL other_addr[%h] cyc%0d flags=%b want %b", a, i, flags_main(), F_IDLE);
                end
                next_cycle();
            end
        end
        req_valid = 0;
    endtask

    task automatic test_back_to_back();
        test_load(3, 1'b1);
        test_other_addr();
    endtask

    // Stores: DONE arrives one cycle after the synchronized tsre is seen
    task automatic test_store();
        logic [15:0] wd;
        int tb_at, ts_at, m1, d;
        logic [5:0] exp_f;
        for (int it = 0; it < 4; it++) begin
            tbre = 0; tsre = 0;
            wait_cycles(3);
            wd    = (it == 0) ? 16'h1234 : 16'($urandom);
            tb_at = (it == 0) ? 10 : $urandom_range(0, 12);
            ts_at = (it == 0) ? 15 : tb_at + $urandom_range(0, 6) - 2;
            if (ts_at < 0) ts_at = 0;
            m1 = ((WR + 2) > (tb_at + 2) ? (WR + 2) : (tb_at + 2)) + 1;
            d  = (m1 > (ts_at + 2) ? m1 : (ts_at + 2)) + 1;
            req_valid = 1; req_write = 1; req_addr = A_DATA; req_wdata = wd;
            for (int i = 0; i <= d; i++) begin
                if (i == tb_at) tbre = 1;
                if (i == ts_at) tsre = 1;
                @(negedge CLK);
                exp_f = {i < d, 1'b1, !(i >= 2 && i <= WR), (i >= 1 && i <= WR + 1), (i >= 1 && i < d), 1'b0};
                n_cmp++;
                if (flags_main() !== exp_f) begin
                    n_err++;
                    $display("FAIL store[%0d] cyc%0d flags=%b want %b (tb@%0d ts@%0d)", it, i, flags_main(), exp_f, tb_at, ts_at);
                end
                if (i == 1) begin
                    n_cmp++;
                    if (bus_dout !== wd[7:0]) begin
                        n_err++;
                        $display("FAIL store_data[%0d] bus_dout=%h want %h", it, bus_dout, wd[7:0]);
                    end
                end
                next_cycle();
            end
            req_valid = 0; req_write = 0;
        end
        tbre = 0; tsre = 0;
        wait_cycles(3);
    endtask

    task automatic test_timeout();
        int d;
        logic [5:0] exp_f;
        tbre = 0; tsre = 0;
        wait_cycles(3);
        d = WR + 2 + TO;
        req_valid_t = 1; req_write = 1; req_addr = A_DATA; req_wdata = 16'($urandom);
        for (int i = 0; i <= d + 1; i++) begin
            if (i == d + 1) req_valid_t = 0;
            @(negedge CLK);
            exp_f = (i == d + 1) ? F_IDLE :
                    {i < d, 1'b1, !(i >= 2 && i <= WR), (i >= 1 && i <= WR + 1), (i >= 1 && i < d), 1'b0};
            n_cmp++;
            if (flags_t() !== exp_f) begin
                n_err++;
                $display("FAIL timeout cyc%0d flags=%b want %b", i, flags_t(), exp_f);
            end
            if (i == 8) begin
                n_cmp++;
                if (flags_main() !== F_IDLE) begin
                    n_err++;
                    $display("FAIL timeout_main_idle flags=%b want %b", flags_main(), F_IDLE);
                end
            end
            next_cycle();
        end
        req_write = 0;
    endtask

    task automatic test_reset_mid_write();
        int rc;
        logic dr;
        logic [5:0] exp_f;
        tbre = 0; tsre = 0;
        wait_cycles(3);
        rc = $urandom_range(1, WR + 1);
        req_valid = 1; req_write = 1; req_addr = A_DATA; req_wdata = 16'($urandom);
        for (int i = 0; i <= rc; i++) begin
            if (i == rc) begin
                RST = 1; req_valid = 0;
            end
            @(negedge CLK);
            exp_f = {i < rc, 1'b1, !(i >= 2 && i <= WR), i >= 1, i >= 1, 1'b0};
            n_cmp++;
            if (flags_main() !== exp_f) begin
                n_err++;
                $display("FAIL rst_wr cyc%0d flags=%b want %b", i, flags_main(), exp_f);
            end
            next_cycle();
        end
        @(negedge CLK);
        n_cmp++;
        if (flags_main() !== F_IDLE || bus_dout !== 8'h00) begin
            n_err++;
            $display("FAIL rst_wr_after flags=%b dout=%h want %b 00", flags_main(), bus_dout, F_IDLE);
        end
        next_cycle();
        RST = 0; req_write = 0;
        dr = 1'($urandom_range(0, 1));
        data_ready = dr; tbre = 1; tsre = 1;
        wait_cycles(3);
        req_valid = 1; req_addr = A_STAT;
        @(negedge CLK);
        n_cmp++;
        if (rdata !== {14'b0, dr, 1'b1} || rdata_valid !== 1'b1) begin
            n_err++;
            $display("FAIL rst_wr_idle rdata=%h valid=%b want %h 1", rdata, rdata_valid, {14'b0, dr, 1'b1});
        end
        next_cycle();
        req_valid = 0;
    endtask

    task automatic test_flush();
        logic [5:0] exp_f, mask;
        tbre = 1; tsre = 1;
        wait_cycles(3);
        req_valid = 1; req_write = 0; req_addr = A_DATA; bus_din = 8'($urandom);
        for (int i = 0; i <= RD + 2; i++) begin
            if (i == 1) req_valid = 0;
            @(negedge CLK);
            exp_f = {i == 0, !(i >= 1 && i <= RD), 1'b1, 1'b0, (i >= 1 && i <= RD), 1'b0};
            mask  = (i == RD + 1) ? 6'b111110 : 6'b111111;
            n_cmp++;
            if ((flags_main() & mask) !== (exp_f & mask)) begin
                n_err++;
                $display("FAIL flush_ld cyc%0d flags=%b want %b", i, flags_main(), exp_f);
            end
            next_cycle();
        end
        req_valid = 1; req_write = 1; req_wdata = 16'($urandom);
        for (int i = 0; i <= WR + 5; i++) begin
            if (i == 1) req_valid = 0;
            @(negedge CLK);
            exp_f = {i == 0, 1'b1, !(i >= 2 && i <= WR), (i >= 1 && i <= WR + 1), (i >= 1 && i <= WR + 3), 1'b0};
            n_cmp++;
            if (flags_main() !== exp_f) begin
                n_err++;
                $display("FAIL flush_st cyc%0d flags=%b want %b", i, flags_main(), exp_f);
            end
            next_cycle();
        end
        req_write = 0;
    endtask

    initial begin
        test_reset();
        test_status_read();
        test_load(4, 1'b0);
        test_store();
        test_timeout();
        test_reset_mid_write();
        test_back_to_back();
        test_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, compared=%0d", n_cmp);
        $fatal(1);
    end

endmodule
